if_stage: RTL

Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction-memory request.
- Contains the IF/ID pipeline register that feeds the decode stage, including the immediate field consumed by the ID-stage immediate extender.
- Handles ID stalls through a one-entry hold buffer, and branch/jump redirects from ID (no delay slot).

---
 rtl/if_stage_if.sv | 23 ++
 rtl/if_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage (master) and the
// instruction memory (slave). The memory is stateless: it looks at the address
// every cycle, and ready=1 means rdata belongs to that same cycle's address.
interface if_stage_if;
   logic [31:0] imem_addr;
   logic        imem_req;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_addr,
      output imem_req,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_addr,
      input  imem_req,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
// This stage owns the PC, issues instruction-memory fetches and holds the
// IF/ID pipeline register. When ID stalls, a fetch that has already completed
// is parked in a one-entry hold buffer. The stage stops fetching until ID
// accepts that buffered word. A redirect from ID has no delay slot: it flushes
// the word that completes in the same cycle and also empties the buffer.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic              clk,
   input  logic              rst,
   if_stage_if.master        imem,
   input  logic              stall_id,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic [31:0]       if_id_instr,
   output logic [31:0]       if_id_pc4,
   output logic [15:0]       if_id_imm,
   output logic              if_id_valid
);

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t      state, state_n;
   logic [31:0] pc, pc_n;
   logic [31:0] pc_plus4;
   logic [31:0] hold_instr, hold_instr_n;
   logic [31:0] hold_pc4, hold_pc4_n;
   logic [31:0] instr_n, pc4_n;
   logic        valid_n;
   logic        fetch_done;
   logic        take_redirect;

   // The fetch address is always the PC. Fetches are requested only in FETCH
   // and never while reset is held.
   assign imem.imem_addr = pc;
   assign imem.imem_req  = !rst && (state == FETCH);

   assign fetch_done    = imem.imem_req && imem.imem_ready;
   // A stalled ID cannot act on a redirect; ID re-asserts it after the stall.
   assign take_redirect = redirect_valid && !stall_id;
   // 32-bit add, so 32'hFFFF_FFFC wraps to 0.
   assign pc_plus4      = pc + 32'd4;

   assign if_id_imm = if_id_instr[15:0];

   // Next-state and next-register selection, evaluated by rule priority.
   always_comb begin
      // NOTE: every signal gets a hold/default value first, so that no path through the
      // branches below leaves one unassigned and infers a latch.
      state_n      = state;
      pc_n         = pc;
      hold_instr_n = hold_instr;
      hold_pc4_n   = hold_pc4;
      instr_n      = if_id_instr;
      pc4_n        = if_id_pc4;
      valid_n      = if_id_valid;

      if (take_redirect) begin
         // Low two bits of the target are dropped to keep word alignment.
         pc_n         = redirect_pc & 32'hFFFF_FFFC;
         hold_instr_n = 32'd0;
         hold_pc4_n   = 32'd0;
         instr_n      = 32'd0;
         pc4_n        = 32'd0;
         valid_n      = 1'b0;
         state_n      = FETCH;
      end else begin
         case (state)
            FETCH: begin
               if (fetch_done) begin
                  pc_n = pc_plus4;
                  if (!stall_id) begin
                     instr_n = imem.imem_rdata;
                     pc4_n   = pc_plus4;
                     valid_n = 1'b1;
                  end else begin
                     // ID is full: park the word until ID is able to take it.
                     hold_instr_n = imem.imem_rdata;
                     hold_pc4_n   = pc_plus4;
                     state_n      = HOLD;
                  end
               end else if (!stall_id) begin
                  instr_n = 32'd0;
                  pc4_n   = 32'd0;
                  valid_n = 1'b0;
               end
            end
            HOLD: begin
               if (!stall_id) begin
                  instr_n = hold_instr;
                  pc4_n   = hold_pc4;
                  valid_n = 1'b1;
                  state_n = FETCH;
               end
            end
            default: state_n = FETCH;
         endcase
      end
   end

   // State, PC, hold buffer and IF/ID register; reset is asynchronous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         hold_instr  <= 32'd0;
         hold_pc4    <= 32'd0;
         if_id_instr <= 32'd0;
         if_id_pc4   <= 32'd0;
         if_id_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register sample the
         // values from before the edge, whatever order the lines are in.
         state       <= state_n;
         pc          <= pc_n;
         hold_instr  <= hold_instr_n;
         hold_pc4    <= hold_pc4_n;
         if_id_instr <= instr_n;
         if_id_pc4   <= pc4_n;
         if_id_valid <= valid_n;
      end
   end

endmodule
